// File: rtl/aemb_dwb_ram.sv
//==============================================================================
// Module   : aemb_dwb_ram
// Brief    : Data-side wishbone RAM responder with registered ack, programmable
//            wait states and big-endian byte-lane writes.
//            Optional macro AEMB_DWB_SELCHK_EN rejects illegal byte selects.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module aemb_dwb_ram #(
    parameter int AW   = 10,
    parameter int WAIT = 0
) (
    input  logic          gclk,
    input  logic          grst,
    input  logic          dwb_stb_i,
    input  logic          dwb_we_i,
    input  logic [AW-1:0] dwb_adr_i,
    input  logic [3:0]    dwb_sel_i,
    input  logic [31:0]   dwb_dat_i,
    output logic [31:0]   dwb_dat_o,
    output logic          dwb_ack_o,
    output logic          dwb_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam int         DEPTH    = 1 << AW;
    localparam logic [3:0] CNT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic        commit;
    logic        sel_ok;
    logic [31:0] rd_word;

    // commit marks the edge entering ACK: the only point memory is touched
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dwb_stb_i) begin
                    if (WAIT > 0) begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = CNT_INIT;
                    end else begin
                        state_nxt = ST_ACK;
                        commit    = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (!dwb_stb_i) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == 4'd0) begin
                    state_nxt = ST_ACK;
                    commit    = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ST_ACK:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

`ifdef AEMB_DWB_SELCHK_EN
    logic err_q;

    always_comb begin
        sel_ok = 1'b0;
        case (dwb_sel_i)
            4'h8, 4'h4, 4'h2, 4'h1, 4'hC, 4'h3, 4'hF: sel_ok = 1'b1;
            default:                                  sel_ok = 1'b0;
        endcase
    end

    always_ff @(posedge gclk) begin
        if (grst) begin
            err_q <= 1'b0;
        end else if (commit) begin
            err_q <= !sel_ok;
        end
    end

    assign dwb_ack_o = (state == ST_ACK) && !err_q;
    assign dwb_err_o = (state == ST_ACK) && err_q;
`else
    assign sel_ok    = 1'b1;
    assign dwb_ack_o = (state == ST_ACK);
    assign dwb_err_o = 1'b0;
`endif

    // one byte-wide array per lane so each lane maps onto its own write enable
    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];

        always_ff @(posedge gclk) begin
            if (!grst && commit && dwb_we_i && sel_ok && dwb_sel_i[i]) begin
                lane_mem[dwb_adr_i] <= dwb_dat_i[8*i +: 8];
            end
        end

        assign rd_word[8*i +: 8] = lane_mem[dwb_adr_i];
    end

    always_ff @(posedge gclk) begin
        if (grst) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            dwb_dat_o <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (commit && !dwb_we_i && sel_ok) begin
                dwb_dat_o <= rd_word;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aemb_dwb_ram.sv
//==============================================================================
// Module   : tb_aemb_dwb_ram
// Brief    : Self-checking bench; instance 0 is AW=4/WAIT=0, instance 1 is
//            AW=10/WAIT=3. Read expectations flow through a scoreboard queue.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_aemb_dwb_ram;

    localparam int AW_A   = 4;
    localparam int AW_B   = 10;
    localparam int WAIT_B = 3;

    logic        gclk = 1'b0;
    logic        grst = 1'b1;
    logic        stb  [2];
    logic        we   [2];
    logic [31:0] badr [2];
    logic [3:0]  sel  [2];
    logic [31:0] dati [2];
    logic [31:0] dato [2];
    logic        ack  [2];
    logic        err  [2];

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] sb [$];

    always #5 gclk = ~gclk;

    aemb_dwb_ram #(.AW(AW_A), .WAIT(0)) dut_a (
        .gclk(gclk), .grst(grst),
        .dwb_stb_i(stb[0]), .dwb_we_i(we[0]), .dwb_adr_i(badr[0][AW_A+1:2]),
        .dwb_sel_i(sel[0]), .dwb_dat_i(dati[0]),
        .dwb_dat_o(dato[0]), .dwb_ack_o(ack[0]), .dwb_err_o(err[0])
    );

    aemb_dwb_ram #(.AW(AW_B), .WAIT(WAIT_B)) dut_b (
        .gclk(gclk), .grst(grst),
        .dwb_stb_i(stb[1]), .dwb_we_i(we[1]), .dwb_adr_i(badr[1][AW_B+1:2]),
        .dwb_sel_i(sel[1]), .dwb_dat_i(dati[1]),
        .dwb_dat_o(dato[1]), .dwb_ack_o(ack[1]), .dwb_err_o(err[1])
    );

    function automatic int lat_exp(input int d);
        return (d == 0) ? 1 : WAIT_B + 1;
    endfunction

    // one master transfer; lat = cycles from strobe to ack/err, 0 on timeout
    task automatic xfer(input int d, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] v,
                        output int lat, output logic [31:0] rd, output logic e);
        stb[d] = 1'b1; we[d] = w; badr[d] = a; sel[d] = s; dati[d] = v;
        lat = 0; rd = '0; e = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge gclk); #1;
            if (ack[d] === 1'b1 || err[d] === 1'b1) begin
                lat = k; rd = dato[d]; e = err[d];
                break;
            end
        end
        stb[d] = 1'b0;
        @(posedge gclk); #1;
    endtask

    task automatic test_reset();
        grst = 1'b1;
        repeat (3) @(posedge gclk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++; if (ack[d] !== 1'b0) begin failures++; $display("FAIL rst_ack[%0d] got=%b exp=0", d, ack[d]); end
            checks++; if (err[d] !== 1'b0) begin failures++; $display("FAIL rst_err[%0d] got=%b exp=0", d, err[d]); end
            checks++; if (dato[d] !== 32'd0) begin failures++; $display("FAIL rst_dat[%0d] got=%h exp=0", d, dato[d]); end
        end
        grst = 1'b0;
        @(posedge gclk); #1;
    endtask

    task automatic test_wait0();
        int lat; logic [31:0] rd, ex; logic e;
        xfer(0, 1'b1, 32'h14, 4'hF, 32'hDEADBEEF, lat, rd, e);
        checks++; if (lat !== 1) begin failures++; $display("FAIL w0_wr_lat got=%0d exp=1", lat); end
        sb.push_back(32'hDEADBEEF);
        xfer(0, 1'b0, 32'h14, 4'hF, 32'h0, lat, rd, e);
        checks++; if (lat !== 1) begin failures++; $display("FAIL w0_rd_lat got=%0d exp=1", lat); end
        ex = sb.pop_front();
        checks++; if (rd !== ex) begin failures++; $display("FAIL w0_rd_dat got=%h exp=%h", rd, ex); end
    endtask

    task automatic test_byte_lanes();
        int lat; logic [31:0] rd, ex; logic e;
        xfer(0, 1'b1, 32'h0C, 4'hF, 32'h00000000, lat, rd, e);
        xfer(0, 1'b1, 32'h0C, 4'h8, 32'hAA000000, lat, rd, e);
        xfer(0, 1'b1, 32'h0C, 4'h1, 32'h000000BB, lat, rd, e);
        sb.push_back(32'hAA0000BB);
        xfer(0, 1'b0, 32'h0C, 4'hF, 32'h0, lat, rd, e);
        ex = sb.pop_front();
        checks++; if (rd !== ex) begin failures++; $display("FAIL lane_8_1 got=%h exp=%h", rd, ex); end
        xfer(0, 1'b1, 32'h0C, 4'h3, 32'h00001234, lat, rd, e);
        sb.push_back(32'hAA001234);
        xfer(0, 1'b0, 32'h0C, 4'hF, 32'h0, lat, rd, e);
        ex = sb.pop_front();
        checks++; if (rd !== ex) begin failures++; $display("FAIL lane_3 got=%h exp=%h", rd, ex); end
    endtask

    task automatic test_wait3();
        int lat, nacks, last, start; logic [31:0] rd, ex; logic e;
        xfer(1, 1'b1, 32'h1C, 4'hF, 32'h12345678, lat, rd, e);
        checks++; if (lat !== lat_exp(1)) begin failures++; $display("FAIL w3_wr_lat got=%0d exp=%0d", lat, lat_exp(1)); end
        sb.push_back(32'h12345678);
        xfer(1, 1'b0, 32'h1C, 4'hF, 32'h0, lat, rd, e);
        checks++; if (lat !== lat_exp(1)) begin failures++; $display("FAIL w3_rd_lat got=%0d exp=%0d", lat, lat_exp(1)); end
        checks++; if (ack[1] !== 1'b0) begin failures++; $display("FAIL w3_pulse got=%b exp=0", ack[1]); end
        ex = sb.pop_front();
        checks++; if (rd !== ex) begin failures++; $display("FAIL w3_rd_dat got=%h exp=%h", rd, ex); end
        // strobe held across three transfers
        for (int i = 0; i < 3; i++) sb.push_back(32'h12345678);
        stb[1] = 1'b1; we[1] = 1'b0; badr[1] = 32'h1C; sel[1] = 4'hF;
        nacks = 0; start = 0; last = start;
        for (int k = 1; k <= 60 && nacks < 3; k++) begin
            @(posedge gclk); #1;
            if (ack[1] === 1'b1) begin
                nacks++;
                if (nacks == 3) stb[1] = 1'b0;
                checks++;
                if (k - last !== ((nacks == 1) ? WAIT_B + 1 : WAIT_B + 2)) begin
                    failures++; $display("FAIL b2b_spacing[%0d] got=%0d exp=%0d", nacks, k - last, (nacks == 1) ? WAIT_B + 1 : WAIT_B + 2);
                end
                ex = sb.pop_front();
                checks++; if (dato[1] !== ex) begin failures++; $display("FAIL b2b_dat[%0d] got=%h exp=%h", nacks, dato[1], ex); end
                last = k;
            end
        end
        stb[1] = 1'b0;
        checks++; if (nacks !== 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", nacks); end
        sb.delete();
        @(posedge gclk); #1;
    endtask

    task automatic test_abort();
        int lat; logic [31:0] rd, ex; logic e; logic seen;
        xfer(1, 1'b1, 32'h24, 4'hF, 32'h11223344, lat, rd, e);
        stb[1] = 1'b1; we[1] = 1'b1; badr[1] = 32'h24; sel[1] = 4'hF; dati[1] = 32'hFFFFFFFF;
        repeat (2) @(posedge gclk);
        #1; stb[1] = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge gclk); #1;
            if (ack[1] === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_ack got=%b exp=0", seen); end
        sb.push_back(32'h11223344);
        xfer(1, 1'b0, 32'h24, 4'hF, 32'h0, lat, rd, e);
        ex = sb.pop_front();
        checks++; if (rd !== ex) begin failures++; $display("FAIL abort_mem got=%h exp=%h", rd, ex); end
        // reset while in WAIT
        stb[1] = 1'b1; we[1] = 1'b1; dati[1] = 32'h55555555;
        repeat (2) @(posedge gclk);
        #1; grst = 1'b1;
        @(posedge gclk); #1;
        checks++; if (ack[1] !== 1'b0) begin failures++; $display("FAIL rstw_ack got=%b exp=0", ack[1]); end
        checks++; if (dato[1] !== 32'd0) begin failures++; $display("FAIL rstw_dat got=%h exp=0", dato[1]); end
        stb[1] = 1'b0; grst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge gclk); #1;
            if (ack[1] === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rstw_late_ack got=%b exp=0", seen); end
        sb.push_back(32'h11223344);
        xfer(1, 1'b0, 32'h24, 4'hF, 32'h0, lat, rd, e);
        ex = sb.pop_front();
        checks++; if (rd !== ex) begin failures++; $display("FAIL rstw_mem got=%h exp=%h", rd, ex); end
    endtask

    task automatic test_wrap();
        int lat; logic [31:0] rd, ex; logic e;
        xfer(0, 1'b1, 32'h40, 4'hF, 32'hCAFEF00D, lat, rd, e);
        sb.push_back(32'hCAFEF00D);
        xfer(0, 1'b0, 32'h00, 4'hF, 32'h0, lat, rd, e);
        ex = sb.pop_front();
        checks++; if (rd !== ex) begin failures++; $display("FAIL wrap_alias got=%h exp=%h", rd, ex); end
        sb.push_back(32'hDEADBEEF);
        xfer(0, 1'b0, 32'h54, 4'hF, 32'h0, lat, rd, e);
        ex = sb.pop_front();
        checks++; if (rd !== ex) begin failures++; $display("FAIL wrap_other got=%h exp=%h", rd, ex); end
    endtask

    task automatic test_selchk();
        int lat; logic [31:0] rd, ex; logic e;
        xfer(0, 1'b1, 32'h08, 4'hF, 32'h01020304, lat, rd, e);
        xfer(0, 1'b1, 32'h08, 4'h5, 32'hFFFFFFFF, lat, rd, e);
        checks++; if (lat !== 1) begin failures++; $display("FAIL sel5_lat got=%0d exp=1", lat); end
`ifdef AEMB_DWB_SELCHK_EN
        checks++; if (e !== 1'b1) begin failures++; $display("FAIL sel5_err got=%b exp=1", e); end
        sb.push_back(32'h01020304);
`else
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL sel5_err got=%b exp=0", e); end
        sb.push_back(32'h01FF03FF);
`endif
        xfer(0, 1'b0, 32'h08, 4'hF, 32'h0, lat, rd, e);
        ex = sb.pop_front();
        checks++; if (rd !== ex) begin failures++; $display("FAIL sel5_mem got=%h exp=%h", rd, ex); end
        xfer(0, 1'b1, 32'h08, 4'hC, 32'hAABB0000, lat, rd, e);
        checks++; if (e !== 1'b0 || lat !== 1) begin failures++; $display("FAIL selC_ack got_err=%b lat=%0d exp_err=0 lat=1", e, lat); end
`ifdef AEMB_DWB_SELCHK_EN
        sb.push_back(32'hAABB0304);
`else
        sb.push_back(32'hAABB03FF);
`endif
        xfer(0, 1'b0, 32'h08, 4'hF, 32'h0, lat, rd, e);
        ex = sb.pop_front();
        checks++; if (rd !== ex) begin failures++; $display("FAIL selC_mem got=%h exp=%h", rd, ex); end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            stb[d] = 1'b0; we[d] = 1'b0; badr[d] = '0; sel[d] = '0; dati[d] = '0;
        end
        test_reset();
        test_wait0();
        test_byte_lanes();
        test_wait3();
        test_abort();
        test_wrap();
        test_selchk();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
